accum_calc_display: RTL and testbench

Parametrised signed accumulator calculator with a built-in multiplexed seven-segment display driver. It is the next generation of the lab calculator: operand width and digit count are generic, subtraction is supported, and the sign is shown correctly. Button edges are detected internally, so one press performs exactly one operation. It sits between the board switches and buttons and the SSD/AN pins, on the single system clock.

---
 rtl/accum_calc_display.sv | 163 ++++++++++++++++
 tb/tb_accum_calc_display.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/accum_calc_display.sv
// Signed add/subtract accumulator with a multiplexed active-low seven-segment display.
// Optional build macro CALC_SATURATE_EN clamps the result on overflow instead of wrapping.
module accum_calc_display #(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              add,
    input  logic              sub,
    output logic [WIDTH-1:0]  result,
    output logic              overflow,
    output logic [6:0]        SSD,
    output logic [DIGITS-1:0] AN
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIB_W = DIGITS * 4;

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             add_q, sub_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       ssd_q, ssd_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic             add_ev_s, sub_ev_s;
    logic [WIDTH-1:0] sum_s, diff_s;
    logic             add_ovf_s, sub_ovf_s;
    logic             neg_s;
    logic [WIDTH-1:0] mag_s;
    logic [NIB_W-1:0] mag_ext_s;
    logic [3:0]       nib_s;

    // Hex nibble to active-low {a,b,c,d,e,f,g} glyph.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            4'hF:    g = 7'b0111000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    assign add_ev_s  = add & ~add_q;
    assign sub_ev_s  = sub & ~sub_q;
    assign sum_s     = result_q + data_in;
    assign diff_s    = result_q - data_in;
    assign add_ovf_s = (result_q[WIDTH-1] == data_in[WIDTH-1]) && (sum_s[WIDTH-1]  != result_q[WIDTH-1]);
    assign sub_ovf_s = (result_q[WIDTH-1] != data_in[WIDTH-1]) && (diff_s[WIDTH-1] != result_q[WIDTH-1]);

    // Accumulator next state; simultaneous add and sub presses cancel to a no-op.
    always_comb begin
        result_d = result_q;
        ovf_d    = ovf_q;
        if (add_ev_s && !sub_ev_s) begin
            result_d = sum_s;
            ovf_d    = add_ovf_s;
        end else if (sub_ev_s && !add_ev_s) begin
            result_d = diff_s;
            ovf_d    = sub_ovf_s;
        end else begin
            result_d = result_q;
            ovf_d    = ovf_q;
        end
`ifdef CALC_SATURATE_EN
        // Overflow direction always follows the sign of the old accumulator.
        if (ovf_d && (add_ev_s ^ sub_ev_s)) begin
            result_d = result_q[WIDTH-1] ? NEG_MIN : POS_MAX;
        end else begin
            result_d = result_d;
        end
`endif
    end

    // Digit dwell counter and digit index.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = {CNT_W{1'b0}};
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    assign neg_s     = result_q[WIDTH-1];
    assign mag_s     = neg_s ? (~result_q + WIDTH'(1)) : result_q;
    assign mag_ext_s = {{(NIB_W - WIDTH){1'b0}}, mag_s};

    // Glyph and anode for the digit selected on this edge; leftmost digit carries the sign.
    always_comb begin
        nib_s = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib_s = mag_ext_s[i*4 +: 4];
            end else begin
                nib_s = nib_s;
            end
        end
        if (idx_d == IDX_W'(DIGITS - 1)) begin
            ssd_d = neg_s ? 7'b1111110 : 7'b1111111;
        end else begin
            ssd_d = hex_glyph(nib_s);
        end
        an_d = ~(DIGITS'(1) << idx_d);
    end

    // State registers; edge-detect history tracks the buttons even during reset.
    always_ff @(posedge Clk) begin
        add_q <= add;
        sub_q <= sub;
        if (reset) begin
            result_q <= {WIDTH{1'b0}};
            ovf_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            ssd_q    <= 7'b0000001;
            an_q     <= ~DIGITS'(1);
        end else begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ssd_q    <= ssd_d;
            an_q     <= an_d;
        end
    end

    assign result   = result_q;
    assign overflow = ovf_q;
    assign SSD      = ssd_q;
    assign AN       = an_q;

endmodule

// File: tb/tb_accum_calc_display.sv
// Directed bench for accum_calc_display with WIDTH=4, DIGITS=4, REFRESH_DIV=4.
module tb_accum_calc_display;

    logic       Clk = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic       add, sub;
    logic [3:0] result;
    logic       overflow;
    logic [6:0] SSD;
    logic [3:0] AN;

    int checks   = 0;
    int failures = 0;

    accum_calc_display #(.WIDTH(4), .DIGITS(4), .REFRESH_DIV(4)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .data_in  (data_in),
        .add      (add),
        .sub      (sub),
        .result   (result),
        .overflow (overflow),
        .SSD      (SSD),
        .AN       (AN)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_add(input logic [3:0] d);
        data_in = d; add = 1'b1; tick();
        add = 1'b0; tick();
    endtask

    task automatic press_sub(input logic [3:0] d);
        data_in = d; sub = 1'b1; tick();
        sub = 1'b0; tick();
    endtask

    task automatic wait_an(input string tag, input logic [3:0] target);
        int n = 0;
        while (AN !== target && n < 40) begin
            tick();
            n++;
        end
        chk(tag, AN, target);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; data_in = 4'h0; add = 1'b0; sub = 1'b0;
        do_reset(2);
        chk("rst_result", result, 4'h0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_an", AN, 4'b1110);
        chk("rst_ssd", SSD, 7'b0000001);
        tick();
        chk("post_rst_an", AN, 4'b1110);
        chk("post_rst_ssd", SSD, 7'b0000001);

        // Add chain and positive overflow
        press_add(4'd3);
        chk("add3", result, 4'b0011);
        press_add(4'd4);
        chk("add4", result, 4'b0111);
        chk("add4_ovf", overflow, 1'b0);
        press_add(4'd1);
`ifdef CALC_SATURATE_EN
        chk("add1_sat", result, 4'b0111);
`else
        chk("add1_wrap", result, 4'b1000);
`endif
        chk("add1_ovf", overflow, 1'b1);

        // Subtraction and sign display
        do_reset(1);
        press_sub(4'd5);
        chk("sub5", result, 4'b1011);
        chk("sub5_ovf", overflow, 1'b0);
        wait_an("wait_an_0111", 4'b0111);
        chk("sign_minus", SSD, 7'b1111110);
        wait_an("wait_an_1110", 4'b1110);
        chk("digit0_5", SSD, 7'b0100100);
        wait_an("wait_an_1101", 4'b1101);
        chk("digit1_0", SSD, 7'b0000001);
        press_sub(4'd3);
        chk("sub3_to_m8", result, 4'b1000);
        chk("sub3_ovf", overflow, 1'b0);
        wait_an("wait_an_1110_m8", 4'b1110);
        chk("digit0_8", SSD, 7'b0000000);
        press_sub(4'd4);
`ifdef CALC_SATURATE_EN
        chk("sub4_sat", result, 4'b1000);
`else
        chk("sub4_wrap", result, 4'b0100);
`endif
        chk("sub4_ovf", overflow, 1'b1);

        // Held button gives exactly one increment
        data_in = 4'd1; add = 1'b1;
        tick();
`ifdef CALC_SATURATE_EN
        chk("hold_first", result, 4'b1001);
        repeat (19) tick();
        chk("hold_once", result, 4'b1001);
`else
        chk("hold_first", result, 4'b0101);
        repeat (19) tick();
        chk("hold_once", result, 4'b0101);
`endif
        chk("hold_ovf", overflow, 1'b0);
        add = 1'b0; tick();

        // Simultaneous add and sub cancel
        data_in = 4'd2; add = 1'b1; sub = 1'b1;
        tick();
`ifdef CALC_SATURATE_EN
        chk("both_result", result, 4'b1001);
`else
        chk("both_result", result, 4'b0101);
`endif
        chk("both_ovf", overflow, 1'b0);
        add = 1'b0; sub = 1'b0; tick();

        // Button held through reset release is not an event
        add = 1'b1; data_in = 4'd1;
        do_reset(1);
        tick();
        chk("held_thru_rst", result, 4'h0);
        add = 1'b0; tick();

        // Scan order and dwell from a fresh reset
        do_reset(1);
        for (int k = 0; k < 20; k++) begin
            logic [3:0] exp_an;
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            chk($sformatf("scan_k%0d", k), AN, exp_an);
            tick();
        end

        // Reset in mid-scan restarts at digit 0 with a full dwell
        do_reset(1);
        repeat (9) tick();
        chk("mid_an_1011", AN, 4'b1011);
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rescan_k%0d", k), AN, 4'b1110);
            tick();
        end
        chk("rescan_next", AN, 4'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
